// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN host-side image loader.
package snn_pkg;

   typedef enum logic [2:0] {
      LOAD,
      UNPACK,
      START,
      RUN,
      TX,
      TX_WAIT
   } loader_state_t;

   localparam int          NUM_PIX_DEF = 784;
   localparam logic [7:0]  ASCII_ZERO  = 8'h30;
   localparam int          PIX_W       = 10;
   localparam int          BYTE_BITS   = 8;

endpackage

// File: rtl/snn_byte_unpack.sv
// Serialises one received byte into eight pixel bits, LSB first, one bit per cycle.
module snn_byte_unpack
   import snn_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_load,
   input  logic [BYTE_BITS-1:0] i_data,
   output logic                 o_busy,
   output logic                 o_last,
   output logic                 o_bit
);

   logic [BYTE_BITS-1:0] r_shift;
   logic [2:0]           r_bit_cnt;
   logic                 r_busy;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_busy    <= 1'b0;
      end else if (i_load) begin
         r_shift   <= i_data;
         r_bit_cnt <= '0;
         r_busy    <= 1'b1;
      end else if (r_busy) begin
         r_shift   <= {1'b0, r_shift[BYTE_BITS-1:1]};
         r_bit_cnt <= r_bit_cnt + 3'd1;
         if (r_bit_cnt == 3'd7) r_busy <= 1'b0;
      end
   end

   assign o_busy = r_busy;
   assign o_last = r_busy && (r_bit_cnt == 3'd7);
   assign o_bit  = r_shift[0];

endmodule

// File: rtl/snn_img_loader.sv
// Loads a packed 1-bit image into the input RAM, runs snn_core, returns the digit as ASCII.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module snn_img_loader
   import snn_pkg::*;
#(
   parameter int         NUM_PIX    = NUM_PIX_DEF,
   parameter logic [7:0] ASCII_BASE = ASCII_ZERO
`ifdef LOADER_TIMEOUT_EN
   , parameter int       TIMEOUT_CYC = 5_000_000
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_rdy,
   input  logic [7:0]       rx_data,
   input  logic             tx_done,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   input  logic [PIX_W-1:0] addr_core,
   input  logic             done_core,
   input  logic [3:0]       digit_core,
   output logic             start_core,
   output logic [PIX_W-1:0] ram_addr,
   output logic             ram_we,
   output logic             ram_data,
   output logic             overrun
);

   localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NUM_PIX - 1);
   localparam logic [PIX_W-1:0] NUM_PIX_L = PIX_W'(NUM_PIX);

   loader_state_t    r_state;
   logic [PIX_W-1:0] r_pix_cnt;
   logic             r_tx_start;
   logic [7:0]       r_tx_data;
   logic             r_start_core;
   logic             r_overrun;

   logic w_load;
   logic w_busy;
   logic w_last;
   logic w_bit;

`ifdef LOADER_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   logic [IDLE_W-1:0] r_idle;
`endif

   assign w_load = (r_state == LOAD) && rx_rdy;

   snn_byte_unpack u_unpack (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_data (rx_data),
      .o_busy (w_busy),
      .o_last (w_last),
      .o_bit  (w_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= LOAD;
         r_pix_cnt    <= '0;
         r_tx_start   <= 1'b0;
         r_tx_data    <= '0;
         r_start_core <= 1'b0;
         r_overrun    <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
         r_idle       <= '0;
`endif
      end else begin
         r_tx_start   <= 1'b0;
         r_start_core <= 1'b0;
         // Only LOAD accepts bytes; anything else is lost and flagged.
         if (rx_rdy && (r_state != LOAD)) r_overrun <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
         r_idle <= '0;
`endif
         case (r_state)
            LOAD: begin
               if (rx_rdy) r_state <= UNPACK;
`ifdef LOADER_TIMEOUT_EN
               if (!rx_rdy && (r_pix_cnt != '0) && (r_pix_cnt < NUM_PIX_L)) begin
                  if (r_idle == IDLE_W'(TIMEOUT_CYC - 1)) begin
                     r_pix_cnt <= '0;
                  end else begin
                     r_idle <= r_idle + 1'b1;
                  end
               end
`endif
            end
            UNPACK: begin
               r_pix_cnt <= r_pix_cnt + 1'b1;
               if (w_last) begin
                  if (r_pix_cnt == LAST_PIX) begin
                     r_state      <= START;
                     r_start_core <= 1'b1;
                  end else begin
                     r_state <= LOAD;
                  end
               end
            end
            START: begin
               r_pix_cnt <= '0;
               r_state   <= RUN;
            end
            RUN: begin
               if (done_core) begin
                  r_tx_data  <= ASCII_BASE + {4'd0, digit_core};
                  r_tx_start <= 1'b1;
                  r_state    <= TX;
               end
            end
            TX:      r_state <= TX_WAIT;
            TX_WAIT: if (tx_done) r_state <= LOAD;
            default: r_state <= LOAD;
         endcase
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      ram_addr = r_pix_cnt;
      ram_we   = 1'b0;
      ram_data = 1'b0;
      if (r_state == UNPACK) begin
         ram_we   = w_busy;
         ram_data = w_bit;
      end else if (r_state == RUN) begin
         ram_addr = addr_core;
      end
   end

   assign tx_start   = r_tx_start;
   assign tx_data    = r_tx_data;
   assign start_core = r_start_core;
   assign overrun    = r_overrun;

endmodule
